// File: rtl/cpu_phase_ctrl_if.sv
// cpu_phase_ctrl_if
// Bundles the run/step/stall/halt controls and the phase-strobe outputs of
// the CPU phase sequencer, so they travel together between the CPU top
// level and the sequencer.
//   master : drives RUN, STEP, STALL, HALT_REQ, CONT; observes strobes,
//            PHASE, BUSY, HALTED and INSTR_CNT
//   slave  : the sequencer itself, the mirror of master
// Parameter CNT_W sets the width of INSTR_CNT and must match the sequencer.
interface cpu_phase_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             RUN;
  logic             STEP;
  logic             STALL;
  logic             HALT_REQ;
  logic             CONT;
  logic             CLK_FT;
  logic             CLK_DC;
  logic             CLK_EX;
  logic             CLK_WB;
  logic [1:0]       PHASE;
  logic             BUSY;
  logic             HALTED;
  logic [CNT_W-1:0] INSTR_CNT;

  modport master (
    output RUN, STEP, STALL, HALT_REQ, CONT,
    input  CLK_FT, CLK_DC, CLK_EX, CLK_WB, PHASE, BUSY, HALTED, INSTR_CNT
  );

  modport slave (
    input  RUN, STEP, STALL, HALT_REQ, CONT,
    output CLK_FT, CLK_DC, CLK_EX, CLK_WB, PHASE, BUSY, HALTED, INSTR_CNT
  );
endinterface

// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl
// Run/stop/single-step sequencer for the four-phase instruction cycle
// (fetch, decode, execute, write-back). Produces one-hot phase strobes that
// clock the pipeline stages and counts retired instructions. Execution only
// stops on an instruction boundary; a memory stall freezes the current phase
// and a halt request from decode parks the sequencer after the instruction.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : cpu_phase_ctrl_if.slave
//           inputs  RUN (level), STEP (rising edge), STALL (level),
//                   HALT_REQ (level), CONT (pulse)
//           outputs CLK_FT/CLK_DC/CLK_EX/CLK_WB strobes, PHASE, BUSY,
//                   HALTED, INSTR_CNT[CNT_W-1:0]
module cpu_phase_ctrl #(
  parameter int CNT_W = 16
) (
  input logic             CLK,
  input logic             RST_N,
  cpu_phase_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [3:0]       strobe_q, strobe_d;   // {WB, EX, DC, FT}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             halt_pend_q, halt_pend_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             step_rise;

  assign step_rise = bus.STEP & ~step_q;

  // Next-state logic. Every output is computed here from the next state so
  // that it is registered alongside the state and changes on the same edge.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    strobe_d    = strobe_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    step_d      = bus.STEP;

    case (state_q)
      S_IDLE: begin
        if (bus.RUN) begin
          state_d  = S_RUN;
          phase_d  = 2'd0;
          strobe_d = 4'b0001;
        end else if (step_rise) begin
          state_d  = S_STEP;
          phase_d  = 2'd0;
          strobe_d = 4'b0001;
        end
      end

      S_RUN, S_STEP: begin
        // Remember a halt request seen at any point of the instruction; the
        // clear at end of write-back below takes precedence.
        if (bus.HALT_REQ) begin
          halt_pend_d = 1'b1;
        end
        if (!bus.STALL) begin
          if (phase_q != 2'd3) begin
            phase_d  = phase_q + 2'd1;
            strobe_d = {strobe_q[2:0], 1'b0};
          end else begin
            // End of write-back: the instruction retires here.
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = 2'd0;
            if (halt_pend_q || bus.HALT_REQ) begin
              state_d     = S_HALT;
              strobe_d    = 4'b0000;
              halt_pend_d = 1'b0;
            end else if (state_q == S_STEP || !bus.RUN) begin
              state_d  = S_IDLE;
              strobe_d = 4'b0000;
            end else begin
              // Back-to-back instruction, no gap cycle.
              state_d  = S_RUN;
              strobe_d = 4'b0001;
            end
          end
        end
      end

      S_HALT: begin
        if (bus.CONT) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        phase_d  = 2'd0;
        strobe_d = 4'b0000;
      end
    endcase

    busy_d   = (state_d == S_RUN) || (state_d == S_STEP);
    halted_d = (state_d == S_HALT);
  end

  // State and output registers; reset aborts any instruction in flight
  // without counting it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'd0;
      strobe_q    <= 4'b0000;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      strobe_q    <= strobe_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      halt_pend_q <= halt_pend_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.CLK_FT    = strobe_q[0];
  assign bus.CLK_DC    = strobe_q[1];
  assign bus.CLK_EX    = strobe_q[2];
  assign bus.CLK_WB    = strobe_q[3];
  assign bus.PHASE     = phase_q;
  assign bus.BUSY      = busy_q;
  assign bus.HALTED    = halted_q;
  assign bus.INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb_cpu_phase_ctrl
// Directed bench for cpu_phase_ctrl built with a 4-bit instruction counter
// so that counter wrap-around is reachable in a short run. Inputs change 1
// time unit after the rising edge and outputs are sampled at the same point,
// so each sample reflects the registers loaded by the preceding edge.
module tb_cpu_phase_ctrl;

  localparam int CNT_W = 4;

  logic CLK;
  logic RST_N;
  int   checkCount;
  int   errorCount;

  cpu_phase_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_phase_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  // 10-unit clock period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives all control inputs at once
  task automatic applyStimulus(input logic run, input logic step,
                               input logic stall, input logic haltReq,
                               input logic cont);
    bus.RUN      = run;
    bus.STEP     = step;
    bus.STALL    = stall;
    bus.HALT_REQ = haltReq;
    bus.CONT     = cont;
  endtask

  // Advances to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compares strobes {WB,EX,DC,FT}, PHASE, BUSY and HALTED in one go
  task automatic checkState(input string tag, input logic [3:0] expStb,
                            input logic [1:0] expPhase, input logic expBusy,
                            input logic expHalted);
    checkOutput({tag, ".stb"},
                {28'd0, bus.CLK_WB, bus.CLK_EX, bus.CLK_DC, bus.CLK_FT},
                {28'd0, expStb});
    checkOutput({tag, ".phase"}, {30'd0, bus.PHASE}, {30'd0, expPhase});
    checkOutput({tag, ".busy"}, {31'd0, bus.BUSY}, {31'd0, expBusy});
    checkOutput({tag, ".halted"}, {31'd0, bus.HALTED}, {31'd0, expHalted});
  endtask

  task automatic checkCnt(input string tag, input logic [CNT_W-1:0] expCnt);
    checkOutput({tag, ".cnt"}, {28'd0, bus.INSTR_CNT}, {28'd0, expCnt});
  endtask

  // Holds reset for two cycles with all controls low, then releases it
  task automatic resetDut();
    RST_N = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    RST_N      = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, then STALL/HALT_REQ must not leave IDLE
    tick();
    tick();
    checkState("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkCnt("reset", 4'd0);
    RST_N = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checkState("idleIgnore", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Free run for three instructions, no gaps, then stop at the boundary
    $display("[TB] free run");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkState($sformatf("run%0d", i), 4'(1 << (i % 4)), 2'(i % 4), 1'b1, 1'b0);
      checkCnt($sformatf("run%0d", i), 4'(i / 4));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkState("runStop", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkCnt("runStop", 4'd3);

    // RUN dropped during decode of the second instruction; it still completes
    $display("[TB] run drop mid-instruction");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkState($sformatf("drop%0d", i), 4'(1 << (i % 4)), 2'(i % 4), 1'b1, 1'b0);
      if (i == 5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    checkState("dropIdle", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkCnt("dropIdle", 4'd2);
    tick();
    checkState("dropStay", 4'b0000, 2'd0, 1'b0, 1'b0);

    // STEP held high: exactly one instruction, and a new edge is needed
    $display("[TB] single step");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 4) begin
        checkState($sformatf("step%0d", i), 4'(1 << i), 2'(i), 1'b1, 1'b0);
        checkCnt($sformatf("step%0d", i), 4'd0);
      end else begin
        checkState($sformatf("step%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
        checkCnt($sformatf("step%0d", i), 4'd1);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkState("stepLow", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkState("step2Ft", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkState("step2Wb", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    checkState("step2Idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkCnt("step2Idle", 4'd2);

    // Three stalled cycles in execute stretch the instruction to 7 cycles
    $display("[TB] stall");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    begin
      logic [3:0] stallStb [8];
      logic [1:0] stallPh  [8];
      stallStb = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
      stallPh  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 8; i++) begin
        tick();
        checkState($sformatf("stall%0d", i), stallStb[i], stallPh[i], 1'b1, 1'b0);
        checkCnt($sformatf("stall%0d", i), (i < 7) ? 4'd0 : 4'd1);
        if (i == 2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if (i == 5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // One-cycle HALT_REQ during decode halts after write-back
    $display("[TB] halt");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkState("haltDc", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkState("haltEx", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    checkState("haltWb", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    checkState("halted", 4'b0000, 2'd0, 1'b0, 1'b1);
    checkCnt("halted", 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkState("haltHold", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkState("contIdle", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkState("contRun", 4'b0001, 2'd0, 1'b1, 1'b0);
    checkCnt("contRun", 4'd1);

    // Asynchronous reset during execute of the fifth instruction
    $display("[TB] reset mid-instruction");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) tick();
    checkState("preRst", 4'b0100, 2'd2, 1'b1, 1'b0);
    checkCnt("preRst", 4'd4);
    #2;
    RST_N = 1'b0;
    #1;
    checkState("asyncRst", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkCnt("asyncRst", 4'd0);
    tick();
    RST_N = 1'b1;
    tick();
    checkState("postRst", 4'b0001, 2'd0, 1'b1, 1'b0);
    checkCnt("postRst", 4'd0);

    // 17 instructions on a 4-bit counter: 15 -> 0 -> 1
    $display("[TB] counter wrap");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 68; i++) begin
      tick();
      if (i == 60) checkCnt("wrap15", 4'd15);
      if (i == 64) checkCnt("wrap0", 4'd0);
      if (i == 67) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    checkState("wrapIdle", 4'b0000, 2'd0, 1'b0, 1'b0);
    checkCnt("wrap1", 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/cpu_phase_ctrl.md
Name: cpu_phase_ctrl

Overview:
- Run/stop/single-step sequencer for the CPU's four-phase instruction cycle: fetch, decode, execute, write-back.
- Emits one-hot phase strobes CLK_FT/CLK_DC/CLK_EX/CLK_WB that clock the pipeline stages, plus a retired-instruction counter.
- Stops only at instruction boundaries.
- Honours a memory STALL and a HALT request from decode.

Parameters:
CNT_W, 16, width of retired-instruction counter INSTR_CNT

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
RUN  input  1  level: free-run instructions while high
STEP  input  1  rising edge requests exactly one instruction
STALL  input  1  level: freeze current phase while high
HALT_REQ  input  1  level from decode: stop after current instruction
CONT  input  1  pulse: leave HALTED state
CLK_FT  output  1  fetch strobe
CLK_DC  output  1  decode strobe
CLK_EX  output  1  execute strobe
CLK_WB  output  1  write-back strobe
PHASE  output  2  current phase 0=FT 1=DC 2=EX 3=WB (0 when not busy)
BUSY  output  1  high in S_RUN or S_STEP
HALTED  output  1  high in S_HALT
INSTR_CNT  output  CNT_W  instructions retired since reset

Behaviour:
- Reset (RST_N=0, asynchronous, immediate):
  - state=S_IDLE, PHASE=0, all strobes 0, BUSY=0, HALTED=0, INSTR_CNT=0.
  - Internal step_q=0 and halt_pend=0.
  - Reset asserted mid-instruction aborts it; that instruction is not counted.
- Outputs are flop outputs, updated on the same edge as the state.
- Step edge detection: step_rise = STEP & ~step_q; step_q <= STEP every cycle.
- States:
  - S_IDLE: strobes 0, PHASE 0.
    - RUN=1 -> S_RUN, PHASE<=0, CLK_FT<=1.
    - Else step_rise -> S_STEP, PHASE<=0, CLK_FT<=1.
    - RUN has priority over step_rise.
    - STALL and HALT_REQ are ignored here.
  - S_RUN / S_STEP: exactly one strobe high, the one matching PHASE.
    - STALL=1: PHASE and strobe hold; a strobe may stay high for multiple cycles.
    - STALL=0 and PHASE<3: PHASE++ and the strobe moves to the next phase.
    - STALL=0 and PHASE=3 (end of WB): INSTR_CNT++ (wraps modulo 2^CNT_W), then the next state is chosen in this priority:
      1. halt_pend or HALT_REQ -> S_HALT, strobes 0, halt_pend<=0.
      2. S_STEP -> S_IDLE.
      3. S_RUN with RUN=0 -> S_IDLE.
      4. Otherwise S_RUN, PHASE<=0, CLK_FT<=1. Back-to-back instructions have no gap cycle.
    - halt_pend <= 1 whenever HALT_REQ=1 in S_RUN/S_STEP.
    - RUN dropping mid-instruction does not abort; the instruction completes.
    - step_rise in S_RUN/S_STEP is ignored, not queued.
  - S_HALT: strobes 0, HALTED=1.
    - CONT=1 -> S_IDLE.
    - RUN and STEP are ignored while halted.
    - Leaving S_HALT via CONT with RUN still high: S_IDLE restarts on the following edge.
- Minimum instruction length: 4 cycles, with CLK_FT, CLK_DC, CLK_EX, CLK_WB each high 1 cycle when STALL=0.
- Latency: RUN sampled high at edge k -> CLK_FT high during cycle k..k+1.

Test Plan:
- Reset then RUN=1 for 12 cycles, STALL=0:
  - Strobes cycle FT,DC,EX,WB three times with no gaps.
  - INSTR_CNT=3.
  - RUN=0 at cycle 6 -> the second instruction completes, then S_IDLE with INSTR_CNT=2.
- Single step: STEP held high 10 cycles from S_IDLE:
  - Exactly one FT..WB sequence, then IDLE.
  - INSTR_CNT=1; no second instruction until STEP goes low then high again.
- Stall: RUN=1, STALL=1 for 3 cycles while PHASE=2:
  - CLK_EX high 4 cycles.
  - Instruction takes 7 cycles; INSTR_CNT +1 only after WB.
- Halt: HALT_REQ pulsed 1 cycle during DC:
  - WB completes, then HALTED=1, BUSY=0, strobes 0.
  - RUN=1 has no effect while halted.
  - CONT pulse -> IDLE, then RUN restarts with FT on the next edge.
- Reset mid-op: RST_N low during EX of instruction 5:
  - Asynchronously all outputs 0 and INSTR_CNT=0.
  - After release with RUN=1, first strobe is CLK_FT.
- Counter wrap with CNT_W=4: run 17 instructions -> INSTR_CNT 15 -> 0 -> 1.
